// File: rtl/page_walker_if.sv
// Bundles the translation request, PTE read port and result bus of the
// page-table walker.
interface page_walker_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_va;
  logic [1:0]  req_acc;
  logic [63:0] satp;
  logic [1:0]  priv;
  logic        abort;

  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        resp_valid;
  logic [63:0] resp_pa;
  logic        resp_fault;
  logic [1:0]  resp_level;

  modport slave (
    input  req_valid, req_va, req_acc, satp, priv, abort, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_addr, resp_valid, resp_pa, resp_fault, resp_level
  );

  modport master (
    output req_valid, req_va, req_acc, satp, priv, abort, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_addr, resp_valid, resp_pa, resp_fault, resp_level
  );
endinterface

// File: rtl/page_walker.sv
// Sv39/Sv48 hardware page-table walker: one translation at a time, one PTE
// read outstanding at most, single-cycle result pulse.
module page_walker #(
  parameter int unsigned MAX_LEVELS = 4,
  parameter int unsigned PA_BITS    = 56
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  page_walker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_RESP, S_DRAIN} state_e;

  localparam logic [63:0] PA_MASK = (PA_BITS >= 64) ? '1 : ((64'd1 << PA_BITS) - 64'd1);

  state_e      state_q, state_d;
  logic [63:0] va_q, va_d;
  logic [1:0]  acc_q, acc_d;
  logic [1:0]  priv_q, priv_d;
  logic [1:0]  level_q, level_d;
  logic        mem_req_q, mem_req_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] pa_q, pa_d;
  logic        fault_q, fault_d;
  logic [1:0]  rlevel_q, rlevel_d;

  logic        bare, mode_ok, canon;
  logic [1:0]  start_lvl;
  logic [43:0] pte_ppn;
  logic        pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
  logic        perm_ok, priv_ok, misaligned, leaf_ok;
  logic [63:0] leaf_pa;
  logic        unused_bits;

  function automatic logic [63:0] pte_addr(input logic [43:0] ppn, input logic [63:0] va,
                                           input logic [1:0] lvl);
    logic [8:0] vpn;
    case (lvl)
      2'd0:    vpn = va[20:12];
      2'd1:    vpn = va[29:21];
      2'd2:    vpn = va[38:30];
      default: vpn = va[47:39];
    endcase
    return {8'b0, ppn, vpn, 3'b000} & PA_MASK;
  endfunction

  function automatic logic [63:0] page_off_mask(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return 64'h0000_0000_0000_0FFF;
      2'd1:    return 64'h0000_0000_001F_FFFF;
      2'd2:    return 64'h0000_0000_3FFF_FFFF;
      default: return 64'h0000_007F_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [43:0] super_ppn_mask(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return 44'h0;
      2'd1:    return 44'h1FF;
      2'd2:    return 44'h3_FFFF;
      default: return 44'h7FF_FFFF;
    endcase
  endfunction

  // Request decode, evaluated against the live inputs during the handshake.
  assign bare = (bus.satp[63:60] == 4'd0) || (bus.priv == 2'b11);

  always_comb begin
    mode_ok   = 1'b0;
    start_lvl = 2'd0;
    canon     = 1'b0;
    case (bus.satp[63:60])
      4'd8: begin
        mode_ok   = 1'b1;
        start_lvl = 2'd2;
        canon     = (&bus.req_va[63:38]) || !(|bus.req_va[63:38]);
      end
      4'd9: begin
        if (MAX_LEVELS >= 4) begin
          mode_ok   = 1'b1;
          start_lvl = 2'd3;
          canon     = (&bus.req_va[63:47]) || !(|bus.req_va[63:47]);
        end
      end
      default: ;
    endcase
  end

  assign pte_v   = bus.mem_rdata[0];
  assign pte_r   = bus.mem_rdata[1];
  assign pte_w   = bus.mem_rdata[2];
  assign pte_x   = bus.mem_rdata[3];
  assign pte_u   = bus.mem_rdata[4];
  assign pte_a   = bus.mem_rdata[6];
  assign pte_d   = bus.mem_rdata[7];
  assign pte_ppn = bus.mem_rdata[53:10];

  always_comb begin
    perm_ok = 1'b0;
    priv_ok = 1'b0;
    case (acc_q)
      2'b00:   perm_ok = pte_r;
      2'b01:   perm_ok = pte_w;
      2'b10:   perm_ok = pte_x;
      default: perm_ok = 1'b0;
    endcase
    case (priv_q)
      2'b00:   priv_ok = pte_u;
      2'b01:   priv_ok = !pte_u;
      default: priv_ok = 1'b0;
    endcase
  end

  assign misaligned = |(pte_ppn & super_ppn_mask(level_q));
  assign leaf_ok    = perm_ok && priv_ok && pte_a && !(acc_q == 2'b01 && !pte_d) && !misaligned;
  assign leaf_pa    = (({8'b0, pte_ppn, 12'b0} & ~page_off_mask(level_q)) |
                       (va_q & page_off_mask(level_q))) & PA_MASK;

  assign unused_bits = ^{bus.satp[59:44], bus.mem_rdata[63:54], bus.mem_rdata[9:8], bus.mem_rdata[5]};

  always_comb begin
    state_d    = state_q;
    va_d       = va_q;
    acc_d      = acc_q;
    priv_d     = priv_q;
    level_d    = level_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    pa_d       = pa_q;
    fault_d    = fault_q;
    rlevel_d   = rlevel_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          va_d     = bus.req_va;
          acc_d    = bus.req_acc;
          priv_d   = bus.priv;
          pa_d     = '0;
          fault_d  = 1'b1;
          rlevel_d = '0;
          state_d  = S_RESP;
          if (bare) begin
            pa_d    = bus.req_va & PA_MASK;
            fault_d = 1'b0;
          end else if (mode_ok && !canon) begin
            rlevel_d = start_lvl;
          end else if (mode_ok) begin
            fault_d    = 1'b0;
            level_d    = start_lvl;
            mem_req_d  = 1'b1;
            mem_addr_d = pte_addr(bus.satp[43:0], bus.req_va, start_lvl);
            state_d    = S_WALK;
          end
        end
      end
      S_WALK: begin
        if (bus.abort) begin
          // A read still in flight must be drained before the port is reused.
          if (bus.mem_rvalid || !mem_req_q) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (bus.mem_rvalid) begin
          mem_req_d = 1'b0;
          pa_d      = '0;
          fault_d   = 1'b1;
          rlevel_d  = level_q;
          state_d   = S_RESP;
          if (!pte_v || (!pte_r && pte_w)) begin
            fault_d = 1'b1;
          end else if (!pte_r && !pte_x) begin
            if (level_q != 2'd0) begin
              level_d    = level_q - 2'd1;
              mem_req_d  = 1'b1;
              mem_addr_d = pte_addr(pte_ppn, va_q, level_q - 2'd1);
              state_d    = S_WALK;
            end
          end else if (leaf_ok) begin
            pa_d    = leaf_pa;
            fault_d = 1'b0;
          end
        end
      end
      S_RESP: state_d = S_IDLE;
      S_DRAIN: begin
        if (bus.mem_rvalid) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      va_q       <= '0;
      acc_q      <= '0;
      priv_q     <= '0;
      level_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pa_q       <= '0;
      fault_q    <= 1'b0;
      rlevel_q   <= '0;
    end else begin
      state_q    <= state_d;
      va_q       <= va_d;
      acc_q      <= acc_d;
      priv_q     <= priv_d;
      level_q    <= level_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pa_q       <= pa_d;
      fault_q    <= fault_d;
      rlevel_q   <= rlevel_d;
    end
  end

  assign bus.req_ready  = rst_ni && (state_q == S_IDLE);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_pa    = pa_q;
  assign bus.resp_fault = fault_q;
  assign bus.resp_level = rlevel_q;

endmodule
